// File: rtl/jtframe_slot_arb_pkg.sv
// Shared types and constants for the SDRAM slot arbiter: FSM encoding,
// default address width and the slot-index width helper.
package jtframe_slot_arb_pkg;

  localparam int DEF_AW = 22;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_state_t;

  // Width of a slot index; a single slot still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_slot_arb_if.sv
// SDRAM read-port handshake between the slot arbiter (master) and the
// framework SDRAM controller (slave).
interface jtframe_slot_arb_if
  import jtframe_slot_arb_pkg::*;
#(
  parameter int AW = DEF_AW
) ();

  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   data_read;
  logic          refresh_en;

  modport master (
    output sdram_req, sdram_addr, refresh_en,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr, refresh_en,
    output sdram_ack, data_rdy, data_read
  );

endinterface

// File: rtl/jtframe_arb_rr.sv
// Combinational round-robin picker: first set bit of miss, searching
// upward from last+1 and wrapping modulo SLOTS.
module jtframe_arb_rr #(
  parameter int SLOTS = 5,
  parameter int SW    = 3
) (
  input  logic [SLOTS-1:0] miss,
  input  logic [SW-1:0]    last,
  output logic [SW-1:0]    gnt,
  output logic             any
);

  logic [SW-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value held over and no latch is inferred.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      idx = SW'((int'(last) + k) % SLOTS);
      if (!any && miss[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

endmodule

// File: rtl/jtframe_slot_arb.sv
// Round-robin SDRAM read scheduler with a one-entry cache per ROM slot.
// Reads are issued only on a miss; slot_ok flags a cached word for the address.
module jtframe_slot_arb
  import jtframe_slot_arb_pkg::*;
#(
  parameter int SLOTS = 5,
  parameter int AW    = DEF_AW
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*32-1:0] slot_dout,
  jtframe_slot_arb_if.master  sdram
);

  localparam int SW = sel_w(SLOTS);

  arb_state_t     state, state_nxt;
  logic [AW-1:0]  tag  [SLOTS];
  logic [31:0]    dout [SLOTS];
  logic [SLOTS-1:0] valid, hit, miss;
  logic [SW-1:0]  last, gnt, pick;
  logic           any, block, discard, grant_en, fill_en;

  assign block = downloading | loop_rst;

  always_comb begin
    hit  = '0;
    miss = '0;
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]  = slot_cs[i] & valid[i] & ~block & (tag[i] == slot_addr[i*AW +: AW]);
      miss[i] = slot_cs[i] & ~hit[i];
    end
  end

  jtframe_arb_rr #(.SLOTS(SLOTS), .SW(SW)) u_rr (
    .miss (miss),
    .last (last),
    .gnt  (pick),
    .any  (any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any && !block)   state_nxt = WAIT_ACK;
      WAIT_ACK: if (sdram.sdram_ack) state_nxt = WAIT_RDY;
      WAIT_RDY: if (sdram.data_rdy)  state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram.sdram_req = (state == WAIT_ACK);
    grant_en        = (state == IDLE) && any && !block;
    fill_en         = (state == WAIT_RDY) && sdram.data_rdy;
  end

  // A transfer that overlaps a download or loop reset is completed but its
  // data is dropped, even if the blocking signal has fallen by data_rdy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last             <= SW'(SLOTS-1);
      gnt              <= '0;
      discard          <= 1'b0;
      sdram.sdram_addr <= '0;
      sdram.refresh_en <= 1'b0;
    end else begin
      if (grant_en) begin
        gnt              <= pick;
        last             <= pick;
        discard          <= 1'b0;
        sdram.sdram_addr <= slot_addr[pick*AW +: AW];
      end else if (block && state != IDLE) begin
        discard <= 1'b1;
      end
      sdram.refresh_en <= (state_nxt == IDLE) && !any;
    end
  end

  // NOTE: the cache is a handful of flops rather than a RAM, so it is reset;
  // that gives slot_dout a defined zero after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]  <= '0;
        dout[i] <= '0;
      end
    end else if (block) begin
      valid <= '0;
    end else if (fill_en && !discard) begin
      tag[gnt]   <= sdram.sdram_addr;
      dout[gnt]  <= sdram.data_read;
      valid[gnt] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) slot_ok <= '0;
    else       slot_ok <= hit;
  end

  always_comb begin
    slot_dout = '0;
    for (int i = 0; i < SLOTS; i++) slot_dout[i*32 +: 32] = dout[i];
  end

endmodule
